// File: rtl/prog_loader.sv
// prog_loader: receives a byte stream (count, hi/lo word pairs, XOR checksum)
// and writes the assembled 16-bit words to program memory from address 0.
// It holds the CPU in reset while loading and flags checksum or timeout errors.
module prog_loader #(
  parameter int DataWidth = 8,
  parameter int PC_WIDTH  = 8,
  parameter int IRWidth   = 16,
  parameter int TIMEOUT   = 1023
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 start,
  input  logic [DataWidth-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 mem_wr_en,
  output logic [PC_WIDTH-1:0]  mem_wr_adr,
  output logic [IRWidth-1:0]   mem_wr_data,
  output logic                 cpu_hold,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int IdleW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_HI,
    S_LO,
    S_CHK,
    S_ERR
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 w_active;
  logic                 w_accept;
  logic                 w_timeout;
  logic                 w_last;
  logic                 w_chk_ok;

  logic [8:0]           r_cnt;
  logic [DataWidth-1:0] r_hi;
  logic [DataWidth-1:0] r_chk;
  logic [PC_WIDTH-1:0]  r_adr;
  logic [IdleW-1:0]     r_idle;
  logic                 r_wr_en;
  logic [PC_WIDTH-1:0]  r_wr_adr;
  logic [IRWidth-1:0]   r_wr_data;
  logic                 r_hold;
  logic                 r_done;

  // State register; reset aborts any load in progress.
  always_ff @(posedge clk or posedge res) begin
    if (res) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode: handshake, last-word detection, checksum and idle timeout.
  always_comb begin
    w_next    = r_state;
    w_active  = (r_state == S_LEN) || (r_state == S_HI) ||
                (r_state == S_LO)  || (r_state == S_CHK);
    w_accept  = w_active && in_valid;
    w_timeout = w_active && !w_accept && (r_idle == IdleW'(TIMEOUT - 1));
    w_last    = (r_cnt == 9'd1);
    w_chk_ok  = (in_data == r_chk);
    unique case (r_state)
      S_IDLE, S_ERR: if (start) w_next = S_LEN;
      S_LEN:         if (w_accept) w_next = S_HI;
      S_HI:          if (w_accept) w_next = S_LO;
      S_LO:          if (w_accept) w_next = w_last ? S_CHK : S_HI;
      S_CHK:         if (w_accept) w_next = w_chk_ok ? S_IDLE : S_ERR;
      default:       w_next = S_IDLE;
    endcase
    if (w_timeout) w_next = S_ERR;
  end

  // Datapath: word assembly, running checksum, address/count and write strobe.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_cnt     <= '0;
      r_hi      <= '0;
      r_chk     <= '0;
      r_adr     <= '0;
      r_idle    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_adr  <= '0;
      r_wr_data <= '0;
      r_hold    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      // The idle counter only runs while a load is waiting for a byte.
      if (w_active && !w_accept) r_idle <= r_idle + IdleW'(1);
      else                       r_idle <= '0;
      unique case (r_state)
        S_IDLE, S_ERR: begin
          if (start) begin
            r_adr  <= '0;
            r_chk  <= '0;
            r_hold <= 1'b1;
          end
        end
        S_LEN: begin
          // A count byte of zero encodes a full 256-word program.
          if (w_accept) r_cnt <= (in_data == '0) ? 9'd256 : 9'(in_data);
        end
        S_HI: begin
          if (w_accept) begin
            r_hi  <= in_data;
            r_chk <= r_chk ^ in_data;
          end
        end
        S_LO: begin
          if (w_accept) begin
            r_chk     <= r_chk ^ in_data;
            r_wr_en   <= 1'b1;
            r_wr_adr  <= r_adr;
            r_wr_data <= {r_hi, in_data};
            r_adr     <= r_adr + PC_WIDTH'(1);
            r_cnt     <= r_cnt - 9'd1;
          end
        end
        S_CHK: begin
          // A bad checksum leaves the CPU held: the program in memory is invalid.
          if (w_accept && w_chk_ok) begin
            r_done <= 1'b1;
            r_hold <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = w_active;
  assign busy        = w_active;
  assign err         = (r_state == S_ERR);
  assign mem_wr_en   = r_wr_en;
  assign mem_wr_adr  = r_wr_adr;
  assign mem_wr_data = r_wr_data;
  assign cpu_hold    = r_hold;
  assign done        = r_done;

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader (TIMEOUT shortened to 16 cycles).
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        res;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_wr_en;
  logic [7:0]  mem_wr_adr;
  logic [15:0] mem_wr_data;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  int          n_wr = 0;
  logic [7:0]  log_adr [0:1023];
  logic [15:0] log_dat [0:1023];
  bit          both_seen = 1'b0;

  always #5 clk = ~clk;

  prog_loader #(
    .DataWidth(8),
    .PC_WIDTH (8),
    .IRWidth  (16),
    .TIMEOUT  (16)
  ) dut (
    .clk        (clk),
    .res        (res),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_adr (mem_wr_adr),
    .mem_wr_data(mem_wr_data),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // Write log and done/err exclusivity watch, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_wr_en && n_wr < 1024) begin
      log_adr[n_wr] <= mem_wr_adr;
      log_dat[n_wr] <= mem_wr_data;
      n_wr          <= n_wr + 1;
    end
    if (done && err) both_seen <= 1'b1;
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap, input bit pst);
    int k;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    if (pst) start = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (k >= 50) begin
      bad++;
      $display("FAIL send_accept byte=%h in_ready=%b required=1", b, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic test_reset();
    int base;
    res = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({in_ready, mem_wr_en, cpu_hold, busy, done, err, mem_wr_adr, mem_wr_data} !== 30'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h required=0",
               {in_ready, mem_wr_en, cpu_hold, busy, done, err, mem_wr_adr, mem_wr_data});
    end
    @(negedge clk);
    res = 1'b0;
    pulse_start();
    total++;
    if ({busy, cpu_hold, in_ready, err} !== 4'b1110) begin
      bad++;
      $display("FAIL start_flags got=%b required=1110", {busy, cpu_hold, in_ready, err});
    end
    send(8'h02, 0, 1'b0);
    send(8'h12, 0, 1'b0);
    send(8'h34, 0, 1'b0);
    total++;
    if ({mem_wr_en, mem_wr_adr, mem_wr_data} !== {1'b1, 8'h00, 16'h1234}) begin
      bad++;
      $display("FAIL pre_reset_write got=%b/%h/%h required=1/00/1234", mem_wr_en, mem_wr_adr, mem_wr_data);
    end
    #2;
    res = 1'b1;
    #1;
    total++;
    if ({in_ready, mem_wr_en, cpu_hold, busy, done, err, mem_wr_adr, mem_wr_data} !== 30'd0) begin
      bad++;
      $display("FAIL async_reset got=%h required=0",
               {in_ready, mem_wr_en, cpu_hold, busy, done, err, mem_wr_adr, mem_wr_data});
    end
    base     = n_wr;
    in_data  = 8'hAB;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    res = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if ({in_ready, busy, cpu_hold} !== 3'b000 || n_wr != base) begin
      bad++;
      $display("FAIL idle_after_reset ready/busy/hold=%b writes=%0d required=000/0",
               {in_ready, busy, cpu_hold}, n_wr - base);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_load();
    int base;
    base = n_wr;
    pulse_start();
    send(8'h02, 0, 1'b0);
    send(8'h12, 0, 1'b0);
    send(8'h34, 0, 1'b0);
    total++;
    if ({mem_wr_en, mem_wr_adr, mem_wr_data} !== {1'b1, 8'h00, 16'h1234}) begin
      bad++;
      $display("FAIL load_w0 got=%b/%h/%h required=1/00/1234", mem_wr_en, mem_wr_adr, mem_wr_data);
    end
    @(posedge clk);
    #1;
    total++;
    if ({mem_wr_en, mem_wr_adr, mem_wr_data} !== {1'b0, 8'h00, 16'h1234}) begin
      bad++;
      $display("FAIL load_hold got=%b/%h/%h required=0/00/1234", mem_wr_en, mem_wr_adr, mem_wr_data);
    end
    send(8'hAB, 0, 1'b0);
    send(8'hCD, 0, 1'b0);
    total++;
    if ({mem_wr_en, mem_wr_adr, mem_wr_data} !== {1'b1, 8'h01, 16'hABCD}) begin
      bad++;
      $display("FAIL load_w1 got=%b/%h/%h required=1/01/ABCD", mem_wr_en, mem_wr_adr, mem_wr_data);
    end
    total++;
    if ({cpu_hold, done} !== 2'b10) begin
      bad++;
      $display("FAIL load_before_chk hold/done=%b required=10", {cpu_hold, done});
    end
    send(8'h40, 0, 1'b0);
    total++;
    if ({done, err, cpu_hold, busy, in_ready} !== 5'b10000) begin
      bad++;
      $display("FAIL load_done done/err/hold/busy/ready=%b required=10000",
               {done, err, cpu_hold, busy, in_ready});
    end
    @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0 || n_wr - base != 2) begin
      bad++;
      $display("FAIL load_after done=%b writes=%0d required=0/2", done, n_wr - base);
    end
  endtask

  task automatic test_bad_chk();
    int base;
    base = n_wr;
    pulse_start();
    send(8'h02, 0, 1'b0);
    send(8'h12, 0, 1'b0);
    send(8'h34, 0, 1'b0);
    send(8'hAB, 0, 1'b0);
    send(8'hCD, 0, 1'b0);
    send(8'h41, 0, 1'b0);
    total++;
    if ({err, done, cpu_hold, busy, in_ready} !== 5'b10100) begin
      bad++;
      $display("FAIL badchk err/done/hold/busy/ready=%b required=10100",
               {err, done, cpu_hold, busy, in_ready});
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({err, done} !== 2'b10 || n_wr - base != 2) begin
      bad++;
      $display("FAIL badchk_after err/done=%b writes=%0d required=10/2", {err, done}, n_wr - base);
    end
  endtask

  task automatic test_timeout();
    int base;
    base = n_wr;
    pulse_start();
    total++;
    if ({err, busy, cpu_hold} !== 3'b011) begin
      bad++;
      $display("FAIL restart_from_err err/busy/hold=%b required=011", {err, busy, cpu_hold});
    end
    send(8'h01, 0, 1'b0);
    send(8'h12, 0, 1'b0);
    repeat (15) @(posedge clk);
    #1;
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL timeout_early err=%b required=0 after 15 idle", err);
    end
    @(posedge clk);
    #1;
    total++;
    if ({err, busy, cpu_hold} !== 3'b101 || n_wr != base) begin
      bad++;
      $display("FAIL timeout_hit err/busy/hold=%b writes=%0d required=101/0",
               {err, busy, cpu_hold}, n_wr - base);
    end
    pulse_start();
    total++;
    if ({err, busy} !== 2'b01) begin
      bad++;
      $display("FAIL start_clears_err err/busy=%b required=01", {err, busy});
    end
    repeat (20) @(posedge clk);
    #1;
    total++;
    if ({err, busy} !== 2'b10) begin
      bad++;
      $display("FAIL timeout_len err/busy=%b required=10", {err, busy});
    end
  endtask

  task automatic test_full();
    int         base;
    logic [7:0] lo;
    logic [7:0] chk;
    base = n_wr;
    chk  = 8'h00;
    pulse_start();
    send(8'h00, 0, 1'b0);
    for (int i = 0; i < 256; i++) begin
      lo  = 8'(i * 3 + 7);
      chk = chk ^ 8'(i) ^ lo;
      send(8'(i), 0, 1'b0);
      send(lo, 0, 1'b0);
    end
    send(chk, 0, 1'b0);
    total++;
    if ({done, err, n_wr - base} !== {1'b1, 1'b0, 32'd256}) begin
      bad++;
      $display("FAIL full_done done/err=%b writes=%0d required=10/256", {done, err}, n_wr - base);
    end
    for (int i = 0; i < 256; i++) begin
      lo = 8'(i * 3 + 7);
      total++;
      if (log_adr[base + i] !== 8'(i) || log_dat[base + i] !== {8'(i), lo}) begin
        bad++;
        $display("FAIL full_word%0d got=%h/%h required=%h/%h", i,
                 log_adr[base + i], log_dat[base + i], 8'(i), {8'(i), lo});
      end
    end
  endtask

  task automatic test_gaps();
    int base;
    base = n_wr;
    pulse_start();
    send(8'h02, 3, 1'b0);
    send(8'h12, 2, 1'b0);
    send(8'h34, 4, 1'b1);
    total++;
    if ({mem_wr_en, mem_wr_adr, mem_wr_data, busy} !== {1'b1, 8'h00, 16'h1234, 1'b1}) begin
      bad++;
      $display("FAIL gaps_w0 got=%b/%h/%h busy=%b required=1/00/1234 busy=1",
               mem_wr_en, mem_wr_adr, mem_wr_data, busy);
    end
    send(8'hAB, 1, 1'b0);
    send(8'hCD, 5, 1'b1);
    total++;
    if ({mem_wr_en, mem_wr_adr, mem_wr_data, busy} !== {1'b1, 8'h01, 16'hABCD, 1'b1}) begin
      bad++;
      $display("FAIL gaps_w1 got=%b/%h/%h busy=%b required=1/01/ABCD busy=1",
               mem_wr_en, mem_wr_adr, mem_wr_data, busy);
    end
    send(8'h40, 2, 1'b0);
    total++;
    if ({done, err, cpu_hold} !== 3'b100 || n_wr - base != 2) begin
      bad++;
      $display("FAIL gaps_done done/err/hold=%b writes=%0d required=100/2",
               {done, err, cpu_hold}, n_wr - base);
    end
  endtask

  task automatic test_start_wins();
    int base;
    base = n_wr;
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h05;
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
    send(8'h01, 0, 1'b0);
    send(8'h11, 0, 1'b0);
    send(8'h22, 0, 1'b0);
    total++;
    if ({mem_wr_en, mem_wr_adr, mem_wr_data} !== {1'b1, 8'h00, 16'h1122}) begin
      bad++;
      $display("FAIL start_wins_word got=%b/%h/%h required=1/00/1122", mem_wr_en, mem_wr_adr, mem_wr_data);
    end
    send(8'h33, 0, 1'b0);
    total++;
    if ({done, err} !== 2'b10 || n_wr - base != 1) begin
      bad++;
      $display("FAIL start_wins_done done/err=%b writes=%0d required=10/1", {done, err}, n_wr - base);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_bad_chk();
    test_timeout();
    test_full();
    test_gaps();
    test_start_wins();
    repeat (2) @(posedge clk);
    total++;
    if (both_seen !== 1'b0) begin
      bad++;
      $display("FAIL done_err_overlap seen=%b required=0", both_seen);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog time=%0t limit=300000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
